rvv_backend_dispatch_raw_scoreboard: RTL and testbench

//  Multi-channel RAW hazard checker for rvv dispatch, backed by a per-VRF-register pending-write scoreboard.

---
 rtl/rvv_backend_dispatch_raw_scoreboard_pkg.sv | 42 ++++
 rtl/rvv_backend_dispatch_raw_scoreboard_lookup.sv | 65 ++++++
 rtl/rvv_backend_dispatch_raw_scoreboard.sv | 126 ++++++++++++
 tb/tb_rvv_backend_dispatch_raw_scoreboard.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_backend_dispatch_raw_scoreboard_pkg.sv
// ============================================================================
// Module      : rvv_backend_dispatch_raw_scoreboard_pkg
// Description : Shared types and constants for the dispatch RAW scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rvv_backend_dispatch_raw_scoreboard_pkg;

    localparam int VREG_NUM = 32;
    localparam int IDX_W    = $clog2(VREG_NUM);
    localparam int SB_CNT_W = 3;

    typedef logic [SB_CNT_W-1:0] SB_CNT_t;
    typedef logic [IDX_W-1:0]    VREG_IDX_t;

    localparam VREG_IDX_t c_V0_INDEX = '0;

    typedef struct packed {
        VREG_IDX_t vs1_index;
        logic      vs1_valid;
        VREG_IDX_t vs2_index;
        logic      vs2_valid;
        VREG_IDX_t vs3_index;
        logic      vs3_valid;
        logic      vm;
    } SUC_UOP_RAW_t;

    typedef struct packed {
        logic vs1_wait;
        logic vs2_wait;
        logic vd_wait;
        logic v0_wait;
    } RAW_UOP_UOP_t;

    function automatic int unsigned sb_cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rvv_backend_dispatch_raw_scoreboard_lookup.sv
// ============================================================================
// Module      : rvv_backend_dispatch_raw_sb_lookup
// Description : Per-channel RAW check against scoreboard and older channels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvv_backend_dispatch_raw_sb_lookup
    import rvv_backend_dispatch_raw_scoreboard_pkg::*;
#(
    parameter int CH_ID        = 0,
    parameter int DISPATCH_NUM = 2,
    parameter int CNT_W        = SB_CNT_W
) (
    input  logic      [CH_ID:0]                 i_suc_valid,
    input  SUC_UOP_RAW_t                        i_suc_uop,
    input  logic      [CH_ID:0]                 i_suc_w_valid,
    input  VREG_IDX_t [CH_ID:0]                 i_suc_w_index,
    input  logic      [VREG_NUM-1:0]            i_pend,
    input  logic      [VREG_NUM-1:0][CNT_W-1:0] i_cnt,
    output RAW_UOP_UOP_t                        o_raw_wait,
    output logic                                o_cnt_full
);

    localparam int c_SUM_W = CNT_W + $clog2(DISPATCH_NUM + 1) + 1;
    localparam logic [c_SUM_W-1:0] c_CNT_MAX = c_SUM_W'(sb_cnt_max(CNT_W));

    logic [VREG_NUM-1:0] w_older_wr;
    logic [VREG_NUM-1:0] w_busy;
    logic [c_SUM_W-1:0]  w_older_same;
    logic [c_SUM_W-1:0]  w_dst_total;
    VREG_IDX_t           w_dst;

    assign w_dst = i_suc_w_index[CH_ID];

    // Older channels in the same group act as not-yet-recorded allocations.
    always_comb begin
        w_older_wr   = '0;
        w_older_same = '0;
        for (int j = 0; j < CH_ID; j++) begin
            if (i_suc_valid[j] && i_suc_w_valid[j]) begin
                w_older_wr[i_suc_w_index[j]] = 1'b1;
                if (i_suc_w_index[j] == w_dst) begin
                    w_older_same = w_older_same + c_SUM_W'(1);
                end
            end
        end
    end

    assign w_busy = i_pend | w_older_wr;

    always_comb begin
        o_raw_wait          = '0;
        o_raw_wait.vs1_wait = i_suc_valid[CH_ID] & i_suc_uop.vs1_valid & w_busy[i_suc_uop.vs1_index];
        o_raw_wait.vs2_wait = i_suc_valid[CH_ID] & i_suc_uop.vs2_valid & w_busy[i_suc_uop.vs2_index];
        o_raw_wait.vd_wait  = i_suc_valid[CH_ID] & i_suc_uop.vs3_valid & w_busy[i_suc_uop.vs3_index];
        o_raw_wait.v0_wait  = i_suc_valid[CH_ID] & ~i_suc_uop.vm      & w_busy[c_V0_INDEX];
    end

    assign w_dst_total = c_SUM_W'(i_cnt[w_dst]) + w_older_same + c_SUM_W'(1);
    assign o_cnt_full  = i_suc_w_valid[CH_ID] & (w_dst_total > c_CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/rvv_backend_dispatch_raw_scoreboard.sv
// ============================================================================
// Module      : rvv_backend_dispatch_raw_scoreboard
// Description : Pending-write counter scoreboard with multi-channel RAW check.
//               Optional macro RAW_SB_WB_BYPASS_EN lets same-cycle writebacks
//               release hazards.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvv_backend_dispatch_raw_scoreboard
    import rvv_backend_dispatch_raw_scoreboard_pkg::*;
#(
    parameter int DISPATCH_NUM = 2,
    parameter int WB_NUM       = 4,
    parameter int CNT_W        = SB_CNT_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_flush,
    input  logic         [DISPATCH_NUM-1:0] i_suc_valid,
    input  SUC_UOP_RAW_t [DISPATCH_NUM-1:0] i_suc_uop,
    input  logic         [DISPATCH_NUM-1:0] i_suc_w_valid,
    input  VREG_IDX_t    [DISPATCH_NUM-1:0] i_suc_w_index,
    input  logic         [DISPATCH_NUM-1:0] i_dispatch_fire,
    input  logic         [WB_NUM-1:0]       i_wb_valid,
    input  VREG_IDX_t    [WB_NUM-1:0]       i_wb_index,
    output RAW_UOP_UOP_t [DISPATCH_NUM-1:0] o_raw_wait,
    output logic         [DISPATCH_NUM-1:0] o_cnt_full,
    output logic                            o_sb_busy,
    output logic                            o_sb_err
);

    localparam int c_ACC_W = CNT_W + $clog2(DISPATCH_NUM + WB_NUM + 1) + 1;
    localparam logic [c_ACC_W-1:0] c_ACC_MAX = c_ACC_W'(sb_cnt_max(CNT_W));

    logic [VREG_NUM-1:0][CNT_W-1:0]   r_cnt;
    logic                             r_sb_err;

    logic [VREG_NUM-1:0][c_ACC_W-1:0] w_inc;
    logic [VREG_NUM-1:0][c_ACC_W-1:0] w_dec;
    logic [VREG_NUM-1:0][CNT_W-1:0]   w_cnt_nxt;
    logic [VREG_NUM-1:0]              w_pend;
    logic                             w_underflow;

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int r = 0; r < VREG_NUM; r++) begin
            for (int i = 0; i < DISPATCH_NUM; i++) begin
                if (i_dispatch_fire[i] && i_suc_w_valid[i] && (i_suc_w_index[i] == VREG_IDX_t'(r))) begin
                    w_inc[r] = w_inc[r] + c_ACC_W'(1);
                end
            end
            for (int w = 0; w < WB_NUM; w++) begin
                if (i_wb_valid[w] && (i_wb_index[w] == VREG_IDX_t'(r))) begin
                    w_dec[r] = w_dec[r] + c_ACC_W'(1);
                end
            end
        end
    end

    // Allocations and retirements land together; only the net change matters.
    always_comb begin
        logic [c_ACC_W-1:0] w_sum;
        w_cnt_nxt   = r_cnt;
        w_underflow = 1'b0;
        w_sum       = '0;
        for (int r = 0; r < VREG_NUM; r++) begin
            w_sum = c_ACC_W'(r_cnt[r]) + w_inc[r];
            if (w_sum < w_dec[r]) begin
                w_cnt_nxt[r] = '0;
                w_underflow  = 1'b1;
            end else if ((w_sum - w_dec[r]) > c_ACC_MAX) begin
                w_cnt_nxt[r] = '1;
            end else begin
                w_cnt_nxt[r] = CNT_W'(w_sum - w_dec[r]);
            end
        end
    end

    always_comb begin
        w_pend = '0;
        for (int r = 0; r < VREG_NUM; r++) begin
`ifdef RAW_SB_WB_BYPASS_EN
            w_pend[r] = (c_ACC_W'(r_cnt[r]) > w_dec[r]);
`else
            w_pend[r] = |r_cnt[r];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_cnt    <= '0;
            r_sb_err <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_sb_err <= r_sb_err | w_underflow;
        end
    end

    generate
        for (genvar ch = 0; ch < DISPATCH_NUM; ch++) begin : g_lookup
            rvv_backend_dispatch_raw_sb_lookup #(
                .CH_ID        (ch),
                .DISPATCH_NUM (DISPATCH_NUM),
                .CNT_W        (CNT_W)
            ) u_lookup (
                .i_suc_valid   (i_suc_valid[ch:0]),
                .i_suc_uop     (i_suc_uop[ch]),
                .i_suc_w_valid (i_suc_w_valid[ch:0]),
                .i_suc_w_index (i_suc_w_index[ch:0]),
                .i_pend        (w_pend),
                .i_cnt         (r_cnt),
                .o_raw_wait    (o_raw_wait[ch]),
                .o_cnt_full    (o_cnt_full[ch])
            );
        end
    endgenerate

    assign o_sb_busy = |r_cnt;
    assign o_sb_err  = r_sb_err;

endmodule

`default_nettype wire

// File: tb/tb_rvv_backend_dispatch_raw_scoreboard.sv
// ============================================================================
// Module      : tb_rvv_backend_dispatch_raw_scoreboard
// Description : Directed and randomized checks against a counter-array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rvv_backend_dispatch_raw_scoreboard;
    import rvv_backend_dispatch_raw_scoreboard_pkg::*;

    localparam int DN   = 2;
    localparam int WBN  = 4;
    localparam int MAXC = 7;

    logic clk = 1'b0;
    logic rst;
    logic i_flush;
    logic         [DN-1:0]  suc_valid;
    SUC_UOP_RAW_t [DN-1:0]  suc_uop;
    logic         [DN-1:0]  suc_w_valid;
    VREG_IDX_t    [DN-1:0]  suc_w_index;
    logic         [DN-1:0]  fire;
    logic         [WBN-1:0] wb_valid;
    VREG_IDX_t    [WBN-1:0] wb_index;
    RAW_UOP_UOP_t [DN-1:0]  raw_wait;
    logic         [DN-1:0]  cnt_full;
    logic                   sb_busy;
    logic                   sb_err;

    int total = 0;
    int bad   = 0;
    int m_cnt [VREG_NUM];
    bit m_err;

    always #5 clk = ~clk;

    rvv_backend_dispatch_raw_scoreboard #(
        .DISPATCH_NUM (DN),
        .WB_NUM       (WBN),
        .CNT_W        (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_flush         (i_flush),
        .i_suc_valid     (suc_valid),
        .i_suc_uop       (suc_uop),
        .i_suc_w_valid   (suc_w_valid),
        .i_suc_w_index   (suc_w_index),
        .i_dispatch_fire (fire),
        .i_wb_valid      (wb_valid),
        .i_wb_index      (wb_index),
        .o_raw_wait      (raw_wait),
        .o_cnt_full      (cnt_full),
        .o_sb_busy       (sb_busy),
        .o_sb_err        (sb_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A register is pending if writes are outstanding (less this cycle's retirements when bypassing).
    function automatic bit m_pend(input int s);
        int h = 0;
`ifdef RAW_SB_WB_BYPASS_EN
        for (int w = 0; w < WBN; w++)
            if (wb_valid[w] && int'(wb_index[w]) == s) h++;
`endif
        return (m_cnt[s] - h) > 0;
    endfunction

    function automatic bit m_src_busy(input int i, input int s);
        if (m_pend(s)) return 1'b1;
        for (int j = 0; j < i; j++)
            if (suc_valid[j] && suc_w_valid[j] && int'(suc_w_index[j]) == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_raw(input int i);
        logic [3:0] r = 4'b0;
        if (!suc_valid[i]) return r;
        r[3] = suc_uop[i].vs1_valid && m_src_busy(i, int'(suc_uop[i].vs1_index));
        r[2] = suc_uop[i].vs2_valid && m_src_busy(i, int'(suc_uop[i].vs2_index));
        r[1] = suc_uop[i].vs3_valid && m_src_busy(i, int'(suc_uop[i].vs3_index));
        r[0] = !suc_uop[i].vm       && m_src_busy(i, 0);
        return r;
    endfunction

    function automatic bit m_full(input int i);
        int n;
        if (!suc_w_valid[i]) return 1'b0;
        n = m_cnt[suc_w_index[i]];
        for (int j = 0; j < i; j++)
            if (suc_valid[j] && suc_w_valid[j] && suc_w_index[j] == suc_w_index[i]) n++;
        return (n + 1) > MAXC;
    endfunction

    function automatic bit m_any();
        foreach (m_cnt[r]) if (m_cnt[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_all();
        for (int i = 0; i < DN; i++) begin
            chk($sformatf("raw_wait[%0d]", i), 32'(raw_wait[i]), 32'(m_raw(i)));
            chk($sformatf("cnt_full[%0d]", i), 32'(cnt_full[i]), 32'(m_full(i)));
        end
        chk("sb_busy", 32'(sb_busy), 32'(m_any()));
        chk("sb_err", 32'(sb_err), 32'(m_err));
    endtask

    task automatic model_update();
        if (rst || i_flush) begin
            foreach (m_cnt[r]) m_cnt[r] = 0;
            m_err = 1'b0;
        end else begin
            foreach (m_cnt[r]) begin
                int add = 0;
                int sub = 0;
                for (int i = 0; i < DN; i++)
                    if (fire[i] && suc_w_valid[i] && int'(suc_w_index[i]) == r) add++;
                for (int w = 0; w < WBN; w++)
                    if (wb_valid[w] && int'(wb_index[w]) == r) sub++;
                if (m_cnt[r] + add < sub) begin
                    m_cnt[r] = 0;
                    m_err = 1'b1;
                end else begin
                    m_cnt[r] = m_cnt[r] + add - sub;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        i_flush     = 1'b0;
        suc_valid   = '0;
        suc_w_valid = '0;
        suc_w_index = '0;
        fire        = '0;
        wb_valid    = '0;
        wb_index    = '0;
        for (int i = 0; i < DN; i++) begin
            suc_uop[i]    = '0;
            suc_uop[i].vm = 1'b1;
        end
    endtask

    initial begin
        int avail [VREG_NUM];
        bit go;
        idle();
        rst = 1'b1;
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // idle after reset
        repeat (10) tick();

        // single producer/consumer through v5
        suc_valid = 2'b01; suc_w_valid = 2'b01; suc_w_index[0] = 5'd5; fire = 2'b01;
        tick();
        idle();
        suc_valid = 2'b01; suc_uop[0].vs2_index = 5'd5; suc_uop[0].vs2_valid = 1'b1;
        #1 chk("vs2_wait_pending", 32'(raw_wait[0].vs2_wait), 32'd1);
        tick();
        wb_valid = 4'b0001; wb_index[0] = 5'd5;
`ifdef RAW_SB_WB_BYPASS_EN
        #1 chk("vs2_wait_wb_cycle", 32'(raw_wait[0].vs2_wait), 32'd0);
`else
        #1 chk("vs2_wait_wb_cycle", 32'(raw_wait[0].vs2_wait), 32'd1);
`endif
        tick();
        wb_valid = '0;
        #1 chk("vs2_wait_after_wb", 32'(raw_wait[0].vs2_wait), 32'd0);
        tick();

        // intra-group hazard and v0 mask dependency
        idle();
        suc_valid = 2'b11; suc_w_valid = 2'b01; suc_w_index[0] = 5'd3;
        suc_uop[1].vs1_index = 5'd3; suc_uop[1].vs1_valid = 1'b1;
        #1 chk("intra_vs1_wait", 32'(raw_wait[1].vs1_wait), 32'd1);
        chk("intra_ch0_clear", 32'(raw_wait[0]), 32'd0);
        tick();
        idle();
        suc_valid = 2'b01; suc_w_valid = 2'b01; suc_w_index[0] = 5'd0; fire = 2'b01;
        tick();
        idle();
        suc_valid = 2'b10; suc_uop[1].vm = 1'b0;
        #1 chk("v0_wait", 32'(raw_wait[1].v0_wait), 32'd1);
        tick();
        idle();
        wb_valid = 4'b0001; wb_index[0] = 5'd0;
        tick();
        idle();
        tick();

        // counter saturation on v9
        suc_valid = 2'b01; suc_w_valid = 2'b01; suc_w_index[0] = 5'd9; fire = 2'b01;
        repeat (6) tick();
        suc_valid = 2'b11; suc_w_valid = 2'b11; suc_w_index[1] = 5'd9; fire = 2'b00;
        #1 chk("full_ch0_at6", 32'(cnt_full[0]), 32'd0);
        chk("full_ch1_at6", 32'(cnt_full[1]), 32'd1);
        tick();
        suc_valid = 2'b01; suc_w_valid = 2'b01; fire = 2'b01;
        tick();
        fire = 2'b00;
        #1 chk("full_8th", 32'(cnt_full[0]), 32'd1);
        tick();
        fire = 2'b01; wb_valid = 4'b0001; wb_index[0] = 5'd9;
        tick();
        fire = 2'b00; wb_valid = '0;
        #1 chk("full_after_fire_wb", 32'(cnt_full[0]), 32'd1);
        tick();
        idle();
        wb_valid = 4'b1111; wb_index = {4{5'd9}};
        tick();
        wb_valid = 4'b0111;
        tick();
        idle();
        #1 chk("drained_busy", 32'(sb_busy), 32'd0);
        tick();

        // writeback underflow, then flush
        wb_valid = 4'b0001; wb_index[0] = 5'd12;
        tick();
        idle();
        #1 chk("underflow_err", 32'(sb_err), 32'd1);
        tick();
        i_flush = 1'b1; wb_valid = 4'b0001; wb_index[0] = 5'd12;
        tick();
        idle();
        #1 chk("flush_err_clear", 32'(sb_err), 32'd0);
        chk("flush_busy_clear", 32'(sb_busy), 32'd0);
        tick();

        // reset mid-operation with an in-flight writeback afterwards
        suc_valid = 2'b01; suc_w_valid = 2'b01; suc_w_index[0] = 5'd4; fire = 2'b01;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 chk("rst_busy_clear", 32'(sb_busy), 32'd0);
        wb_valid = 4'b0001; wb_index[0] = 5'd4;
        tick();
        idle();
        #1 chk("post_rst_wb_err", 32'(sb_err), 32'd1);
        i_flush = 1'b1;
        tick();
        idle();

        // randomized stress with legal prefix firing
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            for (int i = 0; i < DN; i++) begin
                suc_valid[i]           = 1'($urandom_range(0, 3) != 0);
                suc_uop[i].vs1_index   = VREG_IDX_t'($urandom_range(0, 7));
                suc_uop[i].vs1_valid   = 1'($urandom_range(0, 1));
                suc_uop[i].vs2_index   = VREG_IDX_t'($urandom_range(0, 7));
                suc_uop[i].vs2_valid   = 1'($urandom_range(0, 1));
                suc_uop[i].vs3_index   = VREG_IDX_t'($urandom_range(0, 7));
                suc_uop[i].vs3_valid   = 1'($urandom_range(0, 1));
                suc_uop[i].vm          = 1'($urandom_range(0, 3) != 0);
                suc_w_valid[i]         = suc_valid[i] & 1'($urandom_range(0, 1));
                suc_w_index[i]         = VREG_IDX_t'($urandom_range(0, 7));
            end
            go = 1'b1;
            for (int i = 0; i < DN; i++) begin
                go = go && suc_valid[i] && (m_raw(i) == 4'b0) && !m_full(i)
                        && ($urandom_range(0, 3) != 0);
                fire[i] = go;
            end
            foreach (m_cnt[r]) avail[r] = m_cnt[r];
            for (int w = 0; w < WBN; w++) begin
                int r = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1 && avail[r] > 0) begin
                    avail[r]--;
                    wb_valid[w] = 1'b1;
                    wb_index[w] = VREG_IDX_t'(r);
                end
            end
            i_flush = 1'($urandom_range(0, 79) == 0);
            tick();
        end

        // drain whatever remains outstanding
        for (int k = 0; k < 64 && m_any(); k++) begin
            idle();
            foreach (m_cnt[r]) avail[r] = m_cnt[r];
            for (int w = 0; w < WBN; w++) begin
                for (int r = 0; r < VREG_NUM; r++) begin
                    if (avail[r] > 0) begin
                        avail[r]--;
                        wb_valid[w] = 1'b1;
                        wb_index[w] = VREG_IDX_t'(r);
                        break;
                    end
                end
            end
            tick();
        end
        idle();
        #1 chk("final_busy", 32'(sb_busy), 32'd0);
        chk("final_err", 32'(sb_err), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
